// File: rtl/lsu_mem.sv
// Load/store unit: M1 issues the SRAM byte-lane access, M2 aligns and extends the read word.
// Build option LSU_MISALIGN_TRAP_EN: trap misaligned/illegal accesses instead of force-aligning them.
module lsu_mem #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned XLEN   = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_vld,
  input  logic              req_we,
  input  logic [2:0]        req_f3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wd,
  input  logic [4:0]        req_rd_a,
  input  logic              flush,
  output logic [ADDR_W-1:0] dat_a,
  output logic [3:0]        dat_we,
  output logic [XLEN-1:0]   dat_wd,
  output logic [3:0]        dat_re,
  input  logic [XLEN-1:0]   dat_rd,
  output logic              wb_vld,
  output logic [4:0]        wb_rd_a,
  output logic [XLEN-1:0]   wb_data,
  output logic              exc_vld,
  output logic [XLEN-1:0]   exc_addr,
  output logic              busy
);
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic            legal;
  logic            misal;
  logic            ok;
  logic            accept;
  logic [2:0]      f3_eff;
  logic [3:0]      size_mask;
  logic [XLEN-1:0] addr_eff;
  logic [1:0]      off;

  logic            m2_vld;
  logic [1:0]      m2_off;
  logic [2:0]      m2_f3;
  logic [4:0]      m2_rd;
  logic [XLEN-1:0] ld_shift;
  logic [XLEN-1:0] ld_ext;

  logic            unused_bits;
  assign unused_bits = ^{addr_eff[XLEN-1:ADDR_W], legal, misal};

  // M1: decode size, check alignment, drive SRAM lanes
  always_comb begin
    legal     = 1'b1;
    f3_eff    = req_f3;
    size_mask = 4'b1111;
    case (req_f3)
      F3_B, F3_BU: size_mask = 4'b0001;
      F3_H, F3_HU: size_mask = 4'b0011;
      F3_W:        size_mask = 4'b1111;
      default: begin
        legal  = 1'b0;
        f3_eff = F3_W;
      end
    endcase
    misal = (size_mask[1] & req_addr[0]) | (size_mask[3] & req_addr[1]);
`ifdef LSU_MISALIGN_TRAP_EN
    ok       = legal & ~misal;
    addr_eff = req_addr;
`else
    ok       = 1'b1;
    addr_eff = {req_addr[XLEN-1:2], req_addr[1] & ~size_mask[3], req_addr[0] & ~size_mask[1]};
`endif
    off    = addr_eff[1:0];
    accept = req_vld & ~flush & rstn & ok;
    dat_a  = addr_eff[ADDR_W-1:0];
    dat_wd = req_wd << {off, 3'b000};
    dat_we = 4'b0000;
    dat_re = 4'b0000;
    if (accept) begin
      if (req_we) dat_we = 4'(size_mask << off);
      else        dat_re = 4'(size_mask << off);
    end
  end

  // M2: lane-select and extend the word returned by the SRAM
  always_comb begin
    ld_shift = dat_rd >> {m2_off, 3'b000};
    case (m2_f3)
      F3_B:    ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
      F3_H:    ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
      F3_BU:   ld_ext = {24'd0, ld_shift[7:0]};
      F3_HU:   ld_ext = {16'd0, ld_shift[15:0]};
      default: ld_ext = ld_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      m2_vld  <= 1'b0;
      m2_off  <= 2'd0;
      m2_f3   <= 3'd0;
      m2_rd   <= 5'd0;
      wb_vld  <= 1'b0;
      wb_rd_a <= 5'd0;
      wb_data <= '0;
    end else begin
      m2_vld <= accept & ~req_we;
      if (accept & ~req_we) begin
        m2_off <= off;
        m2_f3  <= f3_eff;
        m2_rd  <= req_rd_a;
      end
      // x0 destination still updates data but never signals write-back
      wb_vld <= m2_vld & ~flush & (m2_rd != 5'd0);
      if (m2_vld & ~flush) begin
        wb_rd_a <= m2_rd;
        wb_data <= ld_ext;
      end
    end
  end

  assign busy = m2_vld;

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      exc_vld  <= 1'b0;
      exc_addr <= '0;
    end else begin
      exc_vld <= req_vld & ~flush & ~ok;
      if (req_vld & ~flush & ~ok) exc_addr <= req_addr;
    end
  end
`else
  assign exc_vld  = 1'b0;
  assign exc_addr = '0;
`endif

endmodule

// File: doc/lsu_mem.md
Name: lsu_mem

Overview:
- Load/store unit stage between the execute stage and the data SRAM port.
- Converts one load/store request per cycle into SRAM byte-lane enables, address and shifted write data.
- Captures the SRAM read word one cycle later, then lane-selects and sign/zero-extends it.
- Delivers a registered write-back result to the register file; misaligned accesses raise a trap flag instead of touching memory.

Parameters:
- ADDR_W, 16, width of the byte address driven to the data SRAM (dat_a).
- XLEN, 32, data path width; fixed at 32, any other value is unsupported.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rstn  in  1  synchronous active-low reset.
- req_vld  in  1  request valid from execute stage.
- req_we  in  1  1 = store, 0 = load.
- req_f3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; others illegal.
- req_addr  in  32  effective byte address.
- req_wd  in  32  store data (rs2), right-aligned.
- req_rd_a  in  5  load destination register.
- flush  in  1  pipeline kill from branch/trap.
- dat_a  out  ADDR_W  byte address to SRAM (SRAM uses [ADDR_W-1:2]).
- dat_we  out  4  byte write enables.
- dat_wd  out  32  lane-shifted store data.
- dat_re  out  4  byte read enables.
- dat_rd  in  32  SRAM read data, valid the cycle after dat_re.
- wb_vld  out  1  load result valid.
- wb_rd_a  out  5  load destination.
- wb_data  out  32  extended load result.
- exc_vld  out  1  misaligned/illegal access trap, one-cycle pulse.
- exc_addr  out  32  faulting address.
- busy  out  1  load in flight (M2 occupied).

Behaviour:
- Reset (rstn=0 at posedge): wb_vld=0, wb_rd_a=0, wb_data=0, exc_vld=0, exc_addr=0, busy=0, M2 entry invalid. dat_we/dat_re are forced 0 while rstn=0.
- Issue stage M1 is combinational from request. A request is accepted when req_vld=1, flush=0, rstn=1 and it is aligned and legal.
  - dat_a = req_addr[ADDR_W-1:0].
  - Store: dat_we = size mask shifted left by addr[1:0] (B 0001, H 0011, W 1111). dat_wd = req_wd shifted left by 8*addr[1:0]. dat_re = 0.
  - Load: dat_re = same mask; dat_we = 0.
  - A rejected request drives dat_we = dat_re = 0.
- Alignment: H requires addr[0]=0; W requires addr[1:0]=00. A misaligned or illegal f3 request issues no SRAM access. Next cycle it sets exc_vld=1 and exc_addr=req_addr. A flushed request never traps.
- M2 (one register stage): an accepted load registers offset, f3 and rd_a, and busy=1 next cycle.
  - In M2, dat_rd is shifted right by 8*offset, then truncated/extended: B/H sign-extend, BU/HU zero-extend, W pass-through.
  - The result registers at the following posedge. wb_vld=1 for exactly one cycle, 2 cycles after acceptance.
  - wb_vld is suppressed when rd_a=0; wb_data still updates.
- Stores produce no wb_vld. Store latency is 1 cycle, when the SRAM commits the write.
- Throughput is one request per cycle, with no back-pressure. Back-to-back loads give wb_vld on consecutive cycles.
- A store followed by a load to the same word returns the new data, since the SRAM writes before the next read.
- flush=1 kills the M1 request (no enables) and invalidates the M2 load, so no wb_vld the following cycle. A store already issued is not undone.
- A simultaneous flush and exc condition gives flush priority.
- Reset mid-operation drops the in-flight load with no wb_vld.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: misaligned/illegal requests behave as above (no access, exc_vld pulse).
- Undefined: exc_vld and exc_addr are tied 0. Misaligned requests are forced aligned: addr[0] cleared for H, addr[1:0] cleared for W, access proceeds. Illegal f3 is treated as W.

Test Plan:
- SW req_addr=0x0000_0010, req_wd=0xDEAD_BEEF -> same cycle dat_a=0x0010, dat_we=1111, dat_wd=0xDEADBEEF, dat_re=0.
- SB addr 0x13, wd 0x0000_00A5 -> dat_we=1000, dat_wd=0xA500_0000. Then LB addr 0x13, rd_a=5 -> 2 cycles later wb_vld=1, wb_rd_a=5, wb_data=0xFFFF_FFA5. LBU gives 0x0000_00A5.
- LH addr 0x12 with word 0x8001_xxxx -> wb_data=0xFFFF_8001. LHU gives 0x0000_8001.
- Back-to-back LW 0x0, 0x4, 0x8 on cycles N..N+2 -> wb_vld high N+2..N+4 with matching data. Flush in cycle N+1 -> no wb_vld for the 0x0 load or the 0x4 load.
- With LSU_MISALIGN_TRAP_EN defined, LW addr 0x6 -> dat_re=0, next cycle exc_vld=1, exc_addr=0x6, no wb_vld. Without the macro, the same request accesses word 0x4 and writes back.
- rstn low for one cycle while an LW is in M2 -> wb_vld stays 0, all outputs 0 after reset, busy=0.
